// File: rtl/div_func.sv
// rtl/div_func.sv - iterative restoring divider for DIV/DIVU, one quotient bit per clock
`timescale 1ns/1ps
module div_func #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] divisor, rem, quo;
  logic [4:0]       cnt;
  logic             neg_q, neg_r;
  logic             accept;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  assign accept = ((state == IDLE) || (state == DONE)) && start;
  assign abs_a  = (is_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b  = (is_signed && b[WIDTH-1]) ? -b : b;

  // quo starts holding the dividend magnitude; its MSB feeds the remainder each step
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, divisor};

  assign busy = (state == RUN) || (state == FIXUP);
  assign done = (state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start) next_state = (b == '0) ? DONE : RUN;
        else       next_state = IDLE;
      end
      RUN:     if (cnt == 5'd0) next_state = FIXUP;
      FIXUP:   next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      divisor     <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= 5'd0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      divisor <= abs_b;
      quo     <= abs_a;
      rem     <= '0;
      cnt     <= 5'd31;
      neg_q   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r   <= is_signed & a[WIDTH-1];
      if (b == '0) begin
        quotient    <= '1;
        remainder   <= a;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      rem <= trial[WIDTH+1] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ~trial[WIDTH+1]};
      cnt <= cnt - 5'd1;
    end else if (state == FIXUP) begin
      // truncating division: remainder follows the dividend's sign
      quotient    <= neg_q ? -quo : quo;
      remainder   <= neg_r ? -rem : rem;
      div_by_zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_func.sv
// tb/tb_div_func.sv - scoreboard bench for div_func with directed vectors
`timescale 1ns/1ps
module tb_div_func;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  div_func #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: every done pulse consumes one scoreboard entry
  always @(negedge clock) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
        check("latency", cyc, e.due);
      end
    end
  end

  task automatic issue(input logic [31:0] aa, input logic [31:0] bb, input logic sg,
                       input logic [31:0] eq, input logic [31:0] er, input logic ez);
    start = 1'b1; a = aa; b = bb; is_signed = sg;
    @(posedge clock); #1;
    start = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom);
    sb.push_back('{eq, er, ez, cyc + (ez ? 0 : 33)});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    int cnt_busy;
    int n;

    repeat (3) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_z", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    cnt_busy = 0;
    repeat (34) begin
      @(negedge clock);
      if (busy) cnt_busy++;
    end
    check("busy_cycles", 32'(cnt_busy), 32'd33);
    wait_idle();

    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    wait_idle();

    issue(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    cnt_busy = 0;
    repeat (2) begin
      @(negedge clock);
      if (busy) cnt_busy++;
    end
    check("dbz_busy", 32'(cnt_busy), 32'd0);
    wait_idle();
    issue(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);
    wait_idle();

    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
    wait_idle();
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    wait_idle();

    // start while busy must be ignored, start during done is accepted
    issue(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);
    repeat (9) @(posedge clock);
    #1 start = 1'b1; a = 32'd1; b = 32'd1; is_signed = 1'b0;
    @(posedge clock);
    #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 40);
    check("b2b_done_seen", {31'd0, done}, 32'd1);
    issue(32'd1, 32'd1, 1'b0, 32'd1, 32'd0, 1'b0);
    wait_idle();

    // reset mid-operation: no scoreboard entry, so any done is flagged
    start = 1'b1; a = 32'd1000; b = 32'd3; is_signed = 1'b0;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (14) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_q", quotient, 32'd0);
    check("abort_r", remainder, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    issue(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_func.md
# div_func

Iterative 32-bit integer divider for the multi-cycle MIPS datapath, the sequential counterpart to the single-cycle combinational ALU function blocks. It executes DIV/DIVU: it latches dividend and divisor on `start`, runs one restoring-division step per clock, and delivers quotient (LO) and remainder (HI) with a one-cycle `done` pulse. The control FSM holds the datapath in its multiply/divide wait state while `busy` is high.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE and clears all outputs.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `is_signed`  in  1  1 = DIV (two's complement), 0 = DIVU; latched with `start`.
- `a`  in  32  dividend; latched with `start`.
- `b`  in  32  divisor; latched with `start`.
- `busy`  out  1  high in RUN and FIXUP.
- `done`  out  1  one-cycle pulse; high only in DONE.
- `quotient`  out  32  LO result; holds until the next result is written.
- `remainder`  out  32  HI result; holds until the next result is written.
- `div_by_zero`  out  1  set with the result when the latched `b` is 0; holds with the result.

## Operation
- States: IDLE, RUN, FIXUP, DONE. Reset state is IDLE.
- IDLE or DONE with `start`=1:
  - latch `|a|`, `|b|` (magnitudes only when `is_signed`=1), the sign of `a`, the XOR of operand signs, and `b==0`.
  - clear the 32-bit partial remainder and load the 5-bit step counter with 31.
  - if `b`==0, go to DONE, else go to RUN.
- IDLE or DONE with `start`=0: go to IDLE.
- RUN, each edge:
  - shift {rem, quo} left by 1, shifting the next dividend bit into the remainder LSB.
  - compute trial = rem − divisor with 33-bit arithmetic.
  - if trial is not negative, rem = trial and quo LSB = 1.
  - decrement the counter. When the counter was 0 on this edge, go to FIXUP.
- FIXUP:
  - `quotient` = quo, negated if the sign XOR is set.
  - `remainder` = rem, negated if the dividend was negative. Remainder takes the dividend's sign (truncating division).
  - go to DONE.
- Divide by zero (takes the DONE path directly from IDLE or DONE):
  - `quotient` = 32'hFFFF_FFFF, `remainder` = the latched raw `a`, `div_by_zero` = 1.
  - this applies regardless of `is_signed`.
- `div_by_zero` is cleared whenever a nonzero-divisor result is written in FIXUP.
- Signed overflow, 0x8000_0000 / 0xFFFF_FFFF: the magnitude path yields `quotient` = 0x8000_0000 and `remainder` = 0. This is the required result, and no flag is raised.
- `start` while `busy` is ignored; the operation in flight is unaffected.
- Inputs `a`, `b` and `is_signed` may change freely after the sampling edge.

## Timing
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0. Internal registers are cleared.
- Edges are numbered from E0, the edge that samples `start`.
  - Normal divide: RUN spans E1..E32; FIXUP writes the outputs at E33; `done`=1 from E33 to E34.
  - Latency is 33 clocks.
  - `busy` is high from after E0 to E33.
- Divide by zero: outputs are written at E0 and `done`=1 from E0 to E1. Latency is 1 clock; `busy` never rises.
- Back-to-back: `start` high while `done`=1 is accepted on that edge. `done` then drops, and the new operation begins with no idle cycle.
- Reset asserted mid-operation: immediate return to IDLE and all outputs cleared. No `done` pulse is produced for the aborted operation.
- Results are stable from the `done` edge until the next result write or reset.

## Test plan
- DIVU `a`=100, `b`=7, one-cycle `start` -> `done` exactly 33 clocks later with `quotient`=14, `remainder`=2, `div_by_zero`=0. `busy` is high for 33 cycles.
- DIV `a`=0xFFFF_FFF9 (−7), `b`=2 -> `quotient`=0xFFFF_FFFD (−3), `remainder`=0xFFFF_FFFF (−1). Repeat with `a`=7, `b`=0xFFFF_FFFE -> `quotient`=0xFFFF_FFFD, `remainder`=1.
- Divide by zero: DIVU `a`=0x1234_5678, `b`=0 -> `done` 1 clock after `start`, `quotient`=0xFFFF_FFFF, `remainder`=0x1234_5678, `div_by_zero`=1. A following 9/3 clears `div_by_zero` and gives `quotient`=3, `remainder`=0.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> `quotient`=0x8000_0000, `remainder`=0. DIVU 0xFFFF_FFFF / 1 -> `quotient`=0xFFFF_FFFF, `remainder`=0.
- Run 50/5, then re-assert `start` with 1/1 at cycle 10 while busy -> result is still 10 r 0 at 33 clocks. Then a `start` with 1/1 during the `done` cycle -> next `done` 33 clocks later with 1 r 0.
- Start 1000/3, assert `reset` at cycle 15 for one cycle -> all outputs 0, no `done` pulse. Next 1000/3 -> 333 r 1 after 33 clocks.
